reg_bank: RTL and testbench



---
 rtl/reg_bank_if.sv | 23 ++
 rtl/reg_bank.sv | 85 ++++++++
 tb/tb_reg_bank.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// Slow-control bus bundle for reg_bank: address/data strobes in, registered
// read data and ack/unknown handshake out.
interface reg_bank_if #(
    parameter int unsigned DW = 32
);
    logic [7:0]    Address;
    logic [DW-1:0] DataIn;
    logic          Read;
    logic          Write;
    logic [DW-1:0] DataOut;
    logic          ack;
    logic          unknown;

    modport master (
        output Address, DataIn, Read, Write,
        input  DataOut, ack, unknown
    );

    modport slave (
        input  Address, DataIn, Read, Write,
        output DataOut, ack, unknown
    );
endinterface

// File: rtl/reg_bank.sv
// Slow-control register bank: NREG read/write control registers and NSTAT
// read-only status words in one address window, one-cycle ack/unknown reply.
module reg_bank #(
    parameter logic [7:0]  BASEAD       = 8'hC0,
    parameter int unsigned DW           = 32,
    parameter int unsigned NREG         = 4,
    parameter int unsigned NSTAT        = 2,
    parameter logic [NREG*DW-1:0] DEFAULTVALUE = '0,
    parameter logic [NREG*DW-1:0] PULSEMASK    = '0
) (
    input  logic                                   Cclk,
    input  logic                                   rst,
    reg_bank_if.slave                              bus,
    input  logic [((NSTAT > 0) ? NSTAT : 1)*DW-1:0] Status,
    output logic [NREG*DW-1:0]                     Q,
    output logic [NREG-1:0]                        Strobe
);

    logic [7:0]         off;
    logic               in_win;
    logic               is_ctrl;
    logic [DW-1:0]      rd_data;
    logic [NREG*DW-1:0] q_nxt;
    logic [NREG-1:0]    strb_nxt;
    logic [DW-1:0]      dout_nxt;
    logic               ack_nxt;
    logic               unk_nxt;

    always_comb begin
        off     = bus.Address - BASEAD;
        in_win  = (bus.Address >= BASEAD) && ({24'd0, off} < NREG + NSTAT);
        is_ctrl = {24'd0, off} < NREG;

        rd_data = '0;
        for (int unsigned k = 0; k < NREG; k++)
            if (off == 8'(k)) rd_data = Q[k*DW +: DW] & ~PULSEMASK[k*DW +: DW];
        for (int unsigned j = 0; j < NSTAT; j++)
            if (off == 8'(NREG + j)) rd_data = Status[j*DW +: DW];

        // Pulse bits clear every cycle unless this cycle's write reloads them.
        q_nxt    = Q & ~PULSEMASK;
        strb_nxt = '0;
        dout_nxt = '0;
        ack_nxt  = 1'b0;
        unk_nxt  = 1'b0;

        if (in_win) begin
            if (bus.Read && bus.Write) begin
                unk_nxt = 1'b1;
            end else if (bus.Write) begin
                if (is_ctrl) begin
                    ack_nxt = 1'b1;
                    for (int unsigned k = 0; k < NREG; k++) begin
                        if (off == 8'(k)) begin
                            q_nxt[k*DW +: DW] = bus.DataIn;
                            strb_nxt[k]       = 1'b1;
                        end
                    end
                end else begin
                    unk_nxt = 1'b1;
                end
            end else if (bus.Read) begin
                ack_nxt  = 1'b1;
                dout_nxt = rd_data;
            end
        end
    end

    always_ff @(posedge Cclk or posedge rst) begin
        if (rst) begin
            Q           <= DEFAULTVALUE & ~PULSEMASK;
            Strobe      <= '0;
            bus.DataOut <= '0;
            bus.ack     <= 1'b0;
            bus.unknown <= 1'b0;
        end else begin
            Q           <= q_nxt;
            Strobe      <= strb_nxt;
            bus.DataOut <= dout_nxt;
            bus.ack     <= ack_nxt;
            bus.unknown <= unk_nxt;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank with BASEAD=C0, NREG=4, NSTAT=2.
module tb_reg_bank;

    localparam logic [127:0] DEFV = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    localparam logic [127:0] PMSK = {32'h0, 32'h0, 32'h0, 32'h1};

    logic         Cclk = 1'b0;
    logic         rst  = 1'b1;
    logic [63:0]  Status = '0;
    logic [127:0] Q;
    logic [3:0]   Strobe;
    int           passed = 0;
    int           total  = 0;

    reg_bank_if #(.DW(32)) bus ();

    reg_bank #(
        .BASEAD(8'hC0), .DW(32), .NREG(4), .NSTAT(2),
        .DEFAULTVALUE(DEFV), .PULSEMASK(PMSK)
    ) dut (
        .Cclk(Cclk), .rst(rst), .bus(bus),
        .Status(Status), .Q(Q), .Strobe(Strobe)
    );

    always #5 Cclk = ~Cclk;

    task automatic acc(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
        bus.Read = rd; bus.Write = wr; bus.Address = a; bus.DataIn = d;
        @(posedge Cclk); #1;
        bus.Read = 1'b0; bus.Write = 1'b0;
    endtask

    task automatic idle();
        @(posedge Cclk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Cclk);
        #1;
        total++; if (Q !== {96'h0, 32'h0} + {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) $display("FAIL reset_q: got %h want %h", Q, {64'h0, 32'hDEADBEEF, 32'h0}); else passed++;
        total++; if (bus.ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.ack); else passed++;
        total++; if (bus.unknown !== 1'b0) $display("FAIL reset_unknown: got %b want 0", bus.unknown); else passed++;
        total++; if (bus.DataOut !== 32'h0) $display("FAIL reset_dout: got %h want 0", bus.DataOut); else passed++;
        total++; if (Strobe !== 4'b0000) $display("FAIL reset_strobe: got %b want 0000", Strobe); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        acc(1'b0, 1'b1, 8'hC2, 32'h12345678);
        total++; if (bus.ack !== 1'b1) $display("FAIL wr_ack: got %b want 1", bus.ack); else passed++;
        total++; if (Strobe !== 4'b0100) $display("FAIL wr_strobe: got %b want 0100", Strobe); else passed++;
        total++; if (Q[95:64] !== 32'h12345678) $display("FAIL wr_q2: got %h want 12345678", Q[95:64]); else passed++;
        total++; if (bus.DataOut !== 32'h0) $display("FAIL wr_dout: got %h want 0", bus.DataOut); else passed++;
        acc(1'b1, 1'b0, 8'hC2, 32'h0);
        total++; if (bus.ack !== 1'b1) $display("FAIL rd_ack: got %b want 1", bus.ack); else passed++;
        total++; if (bus.DataOut !== 32'h12345678) $display("FAIL rd_dout: got %h want 12345678", bus.DataOut); else passed++;
        total++; if (Strobe !== 4'b0000) $display("FAIL rd_strobe: got %b want 0000", Strobe); else passed++;
        idle();
        total++; if (bus.ack !== 1'b0) $display("FAIL idle_ack: got %b want 0", bus.ack); else passed++;
        total++; if (bus.DataOut !== 32'h0) $display("FAIL idle_dout: got %h want 0", bus.DataOut); else passed++;
    endtask

    task automatic test_back_to_back();
        acc(1'b0, 1'b1, 8'hC3, 32'h33330000);
        total++; if (Strobe !== 4'b1000) $display("FAIL b2b_strobe3: got %b want 1000", Strobe); else passed++;
        acc(1'b0, 1'b1, 8'hC0, 32'h0000F0F0);
        total++; if (Strobe !== 4'b0001) $display("FAIL b2b_strobe0: got %b want 0001", Strobe); else passed++;
        acc(1'b1, 1'b0, 8'hC3, 32'h0);
        total++; if (bus.DataOut !== 32'h33330000) $display("FAIL b2b_rd3: got %h want 33330000", bus.DataOut); else passed++;
        acc(1'b1, 1'b0, 8'hC0, 32'h0);
        total++; if (bus.DataOut !== 32'h0000F0F0) $display("FAIL b2b_rd0: got %h want 0000f0f0", bus.DataOut); else passed++;
        total++; if (bus.ack !== 1'b1) $display("FAIL b2b_ack: got %b want 1", bus.ack); else passed++;
    endtask

    task automatic test_pulse();
        acc(1'b0, 1'b1, 8'hC0, 32'h3);
        total++; if (Q[31:0] !== 32'h3) $display("FAIL pulse_set: got %h want 3", Q[31:0]); else passed++;
        acc(1'b1, 1'b0, 8'hC0, 32'h0);
        total++; if (bus.DataOut !== 32'h2) $display("FAIL pulse_rd: got %h want 2", bus.DataOut); else passed++;
        total++; if (Q[31:0] !== 32'h2) $display("FAIL pulse_clr: got %h want 2", Q[31:0]); else passed++;
        acc(1'b0, 1'b1, 8'hC0, 32'h1);
        total++; if (Q[31:0] !== 32'h1) $display("FAIL pulse_w1: got %h want 1", Q[31:0]); else passed++;
        acc(1'b0, 1'b1, 8'hC0, 32'h1);
        total++; if (Q[31:0] !== 32'h1) $display("FAIL pulse_hold: got %h want 1", Q[31:0]); else passed++;
        idle();
        total++; if (Q[31:0] !== 32'h0) $display("FAIL pulse_end: got %h want 0", Q[31:0]); else passed++;
    endtask

    task automatic test_status();
        Status = {32'hA5A5A5A5, 32'h11112222};
        acc(1'b1, 1'b0, 8'hC5, 32'h0);
        total++; if (bus.DataOut !== 32'hA5A5A5A5) $display("FAIL st1_dout: got %h want a5a5a5a5", bus.DataOut); else passed++;
        total++; if (bus.ack !== 1'b1) $display("FAIL st1_ack: got %b want 1", bus.ack); else passed++;
        acc(1'b1, 1'b0, 8'hC4, 32'h0);
        total++; if (bus.DataOut !== 32'h11112222) $display("FAIL st0_dout: got %h want 11112222", bus.DataOut); else passed++;
        acc(1'b0, 1'b1, 8'hC5, 32'hFFFFFFFF);
        total++; if (bus.unknown !== 1'b1) $display("FAIL stwr_unknown: got %b want 1", bus.unknown); else passed++;
        total++; if (bus.ack !== 1'b0) $display("FAIL stwr_ack: got %b want 0", bus.ack); else passed++;
        total++; if (Strobe !== 4'b0000) $display("FAIL stwr_strobe: got %b want 0000", Strobe); else passed++;
    endtask

    task automatic test_window();
        acc(1'b1, 1'b0, 8'hBF, 32'h0);
        total++; if ({bus.ack, bus.unknown} !== 2'b00) $display("FAIL below_resp: got %b want 00", {bus.ack, bus.unknown}); else passed++;
        total++; if (bus.DataOut !== 32'h0) $display("FAIL below_dout: got %h want 0", bus.DataOut); else passed++;
        acc(1'b1, 1'b0, 8'hC6, 32'h0);
        total++; if ({bus.ack, bus.unknown} !== 2'b00) $display("FAIL above_resp: got %b want 00", {bus.ack, bus.unknown}); else passed++;
        acc(1'b0, 1'b1, 8'hC6, 32'hFFFFFFFF);
        total++; if (Strobe !== 4'b0000) $display("FAIL above_strobe: got %b want 0000", Strobe); else passed++;
        acc(1'b1, 1'b1, 8'hC1, 32'hFFFFFFFF);
        total++; if (bus.unknown !== 1'b1) $display("FAIL rw_unknown: got %b want 1", bus.unknown); else passed++;
        total++; if (bus.ack !== 1'b0) $display("FAIL rw_ack: got %b want 0", bus.ack); else passed++;
        total++; if (bus.DataOut !== 32'h0) $display("FAIL rw_dout: got %h want 0", bus.DataOut); else passed++;
        total++; if (Q[63:32] !== 32'hDEADBEEF) $display("FAIL rw_q1: got %h want deadbeef", Q[63:32]); else passed++;
    endtask

    task automatic test_async_reset();
        acc(1'b0, 1'b1, 8'hC3, 32'hABCD0001);
        total++; if (Q[127:96] !== 32'hABCD0001) $display("FAIL ar_q3_set: got %h want abcd0001", Q[127:96]); else passed++;
        total++; if (Strobe !== 4'b1000) $display("FAIL ar_strobe_set: got %b want 1000", Strobe); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (Q[127:96] !== 32'h0) $display("FAIL ar_q3: got %h want 0", Q[127:96]); else passed++;
        total++; if (Q[95:64] !== 32'h0) $display("FAIL ar_q2: got %h want 0", Q[95:64]); else passed++;
        total++; if (Q[63:32] !== 32'hDEADBEEF) $display("FAIL ar_q1: got %h want deadbeef", Q[63:32]); else passed++;
        total++; if (bus.ack !== 1'b0) $display("FAIL ar_ack: got %b want 0", bus.ack); else passed++;
        total++; if (Strobe !== 4'b0000) $display("FAIL ar_strobe: got %b want 0000", Strobe); else passed++;
        #1 rst = 1'b0;
        idle();
        total++; if (bus.ack !== 1'b0) $display("FAIL ar_post_ack: got %b want 0", bus.ack); else passed++;
    endtask

    initial begin
        bus.Address = 8'h0; bus.DataIn = '0; bus.Read = 1'b0; bus.Write = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_pulse();
        test_status();
        test_window();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
